// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and helpers for the RV32I pipeline hazard
//                controller: forwarding select encoding, FSM state encoding,
//                the load result-select code and a register-match helper.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    // E-stage operand source select
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Memory-wait sequencer states
    typedef enum logic [0:0] {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

    // iResultSrcE code identifying a load in E
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // True when a writing stage targets rs. x0 is hard-wired zero and
    // never produces a dependency.
    function automatic logic reg_match(input logic       we,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_controller_if
//  Description : Bundles the pipeline-side hazard inputs and the controller's
//                stall/flush/forward/status outputs.
//                master : pipeline datapath (drives i*, reads o*)
//                slave  : hazard controller (reads i*, drives o*)
//  Ports       : none (signal bundle only); CNT_W sizes the perf counters
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_hazard_controller_if
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [4:0]       iRs1D;
    logic [4:0]       iRs2D;
    logic [4:0]       iRs1E;
    logic [4:0]       iRs2E;
    logic [4:0]       iRdE;
    logic [1:0]       iResultSrcE;
    logic             iPCSrcE;
    logic             iRegWriteM;
    logic [4:0]       iRdM;
    logic             iRegWriteW;
    logic [4:0]       iRdW;
    logic             iMemReqM;
    logic             iMemReadyM;

    logic             oStallF;
    logic             oStallD;
    logic             oStallE;
    logic             oStallM;
    logic             oFlushD;
    logic             oFlushE;
    logic             oFlushW;
    fwd_sel_t         oForwardAE;
    fwd_sel_t         oForwardBE;
    logic             oMemTimeout;
    logic [CNT_W-1:0] oStallCycles;
    logic [CNT_W-1:0] oFlushCount;

    modport master (
        output iRs1D, iRs2D, iRs1E, iRs2E, iRdE, iResultSrcE, iPCSrcE,
               iRegWriteM, iRdM, iRegWriteW, iRdW, iMemReqM, iMemReadyM,
        input  oStallF, oStallD, oStallE, oStallM, oFlushD, oFlushE, oFlushW,
               oForwardAE, oForwardBE, oMemTimeout, oStallCycles, oFlushCount
    );

    modport slave (
        input  iRs1D, iRs2D, iRs1E, iRs2E, iRdE, iResultSrcE, iPCSrcE,
               iRegWriteM, iRdM, iRegWriteW, iRdW, iMemReqM, iMemReadyM,
        output oStallF, oStallD, oStallE, oStallM, oFlushD, oFlushE, oFlushW,
               oForwardAE, oForwardBE, oMemTimeout, oStallCycles, oFlushCount
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller_fwd.sv
`default_nettype none
// ============================================================================
//  Module      : forwarding_unit
//  Description : E-stage forwarding select for one source operand.
//                M-stage result has priority over W-stage result.
//  Ports       : iRs        in  5  source register of the operand in E
//                iRegWriteM in  1  M writes the register file
//                iRdM       in  5  M destination
//                iRegWriteW in  1  W writes the register file
//                iRdW       in  5  W destination
//                oForward   out 2  FWD_M / FWD_W / FWD_RF
//  Revision    : 1.0  initial release
// ============================================================================
module forwarding_unit
    import hazard_pkg::*;
(
    input  wire logic [4:0] iRs,
    input  wire logic       iRegWriteM,
    input  wire logic [4:0] iRdM,
    input  wire logic       iRegWriteW,
    input  wire logic [4:0] iRdW,
    output fwd_sel_t        oForward
);

    always_comb begin
        oForward = FWD_RF;
        if (reg_match(iRegWriteM, iRdM, iRs)) begin
            oForward = FWD_M;
        end else if (reg_match(iRegWriteW, iRdW, iRs)) begin
            oForward = FWD_W;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_controller
//  Description : Hazard and sequencing controller for the 5-stage RV32I pipe.
//                Generates stall/flush controls, E-stage forwarding selects,
//                a memory-wait freeze with sticky timeout flag, and saturating
//                stall-cycle / flush performance counters.
//  Ports       : iClk  in  clock (rising edge)
//                iRst  in  asynchronous active-high reset
//                hz    slave modport: hazard inputs in, controls/status out
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
)(
    input  wire logic                    iClk,
    input  wire logic                    iRst,
    pipeline_hazard_controller_if.slave  hz
);

    localparam int                  c_WAIT_W  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]    c_CNT_MAX = {CNT_W{1'b1}};

    hz_state_t           r_state;
    hz_state_t           w_state_next;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_inc;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    fwd_sel_t            w_fwd_a;
    fwd_sel_t            w_fwd_b;
    logic                w_lu;
    logic                w_ms;
    logic                w_stall_f;
    logic                w_stall_d;
    logic                w_stall_em;
    logic                w_flush_d;
    logic                w_flush_e;
    logic                w_flush_w;

    forwarding_unit u_fwd_a (
        .iRs        (hz.iRs1E),
        .iRegWriteM (hz.iRegWriteM),
        .iRdM       (hz.iRdM),
        .iRegWriteW (hz.iRegWriteW),
        .iRdW       (hz.iRdW),
        .oForward   (w_fwd_a)
    );

    forwarding_unit u_fwd_b (
        .iRs        (hz.iRs2E),
        .iRegWriteM (hz.iRegWriteM),
        .iRdM       (hz.iRdM),
        .iRegWriteW (hz.iRegWriteW),
        .iRdW       (hz.iRdW),
        .oForward   (w_fwd_b)
    );

    assign w_lu = (hz.iResultSrcE == RESULT_SRC_LOAD) && (hz.iRdE != 5'd0) &&
                  ((hz.iRdE == hz.iRs1D) || (hz.iRdE == hz.iRs2D));

    // Mealy memory stall: the freeze applies in the very cycle memory is not ready
    assign w_ms = ((r_state == HZ_RUN)      && hz.iMemReqM && !hz.iMemReadyM) ||
                  ((r_state == HZ_MEM_WAIT) && !hz.iMemReadyM);

    assign w_wait_inc = r_wait_cnt + c_WAIT_W'(1);

    // Next state and stall/flush priority: reset > memory stall > branch > load-use.
    // A branch squashes the load-use pair, and a memory freeze holds E so both
    // resolve once the freeze lifts.
    always_comb begin
        w_state_next = r_state;
        w_stall_f    = 1'b0;
        w_stall_d    = 1'b0;
        w_stall_em   = 1'b0;
        w_flush_d    = 1'b0;
        w_flush_e    = 1'b0;
        w_flush_w    = 1'b0;

        case (r_state)
            HZ_RUN:      if (hz.iMemReqM && !hz.iMemReadyM) w_state_next = HZ_MEM_WAIT;
            HZ_MEM_WAIT: if (hz.iMemReadyM)                 w_state_next = HZ_RUN;
            default:     w_state_next = HZ_RUN;
        endcase

        if (iRst) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_ms) begin
            w_stall_f  = 1'b1;
            w_stall_d  = 1'b1;
            w_stall_em = 1'b1;
            w_flush_w  = 1'b1;
        end else if (hz.iPCSrcE) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_lu) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state     <= HZ_RUN;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;

            // Wait counter holds at the threshold so it never wraps during a long wait
            if ((r_state == HZ_RUN) && (w_state_next == HZ_MEM_WAIT)) begin
                r_wait_cnt <= '0;
            end else if ((r_state == HZ_MEM_WAIT) && (r_wait_cnt != c_TIMEOUT)) begin
                r_wait_cnt <= w_wait_inc;
            end

            if ((r_state == HZ_MEM_WAIT) && (w_wait_inc == c_TIMEOUT)) begin
                r_timeout <= 1'b1;
            end

            if (w_stall_f && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end

            if (!w_ms && hz.iPCSrcE && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.oStallF      = w_stall_f;
    assign hz.oStallD      = w_stall_d;
    assign hz.oStallE      = w_stall_em;
    assign hz.oStallM      = w_stall_em;
    assign hz.oFlushD      = w_flush_d;
    assign hz.oFlushE      = w_flush_e;
    assign hz.oFlushW      = w_flush_w;
    assign hz.oForwardAE   = iRst ? FWD_RF : w_fwd_a;
    assign hz.oForwardBE   = iRst ? FWD_RF : w_fwd_b;
    assign hz.oMemTimeout  = r_timeout;
    assign hz.oStallCycles = r_stall_cnt;
    assign hz.oFlushCount  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_controller
//  Description : Self-checking bench for pipeline_hazard_controller.
//                Vector table for combinational behaviour, directed sequences
//                for load-use, branch, memory wait, timeout, reset and
//                counter saturation. Counters are 4 bits wide here.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_controller;
    import hazard_pkg::*;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.CNT_W(CNT_W)) hz_if();

    pipeline_hazard_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
        .iClk (clk),
        .iRst (rst),
        .hz   (hz_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Output bundle: {fwdA, fwdB, stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    logic [10:0] ctl;
    assign ctl = {hz_if.oForwardAE, hz_if.oForwardBE, hz_if.oStallF, hz_if.oStallD,
                  hz_if.oStallE, hz_if.oStallM, hz_if.oFlushD, hz_if.oFlushE, hz_if.oFlushW};

    typedef struct {
        logic [4:0]  rs1e;
        logic [4:0]  rs2e;
        logic [4:0]  rdm;
        logic        wm;
        logic [4:0]  rdw;
        logic        ww;
        logic [1:0]  rsrc;
        logic [4:0]  rde;
        logic [4:0]  rs1d;
        logic [4:0]  rs2d;
        logic        pcsrc;
        logic        mreq;
        logic        mrdy;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle();
        hz_if.iRs1D = 5'd0;  hz_if.iRs2D = 5'd0;
        hz_if.iRs1E = 5'd0;  hz_if.iRs2E = 5'd0;
        hz_if.iRdE  = 5'd0;  hz_if.iResultSrcE = 2'b00;
        hz_if.iPCSrcE = 1'b0;
        hz_if.iRegWriteM = 1'b0; hz_if.iRdM = 5'd0;
        hz_if.iRegWriteW = 1'b0; hz_if.iRdW = 5'd0;
        hz_if.iMemReqM = 1'b0;   hz_if.iMemReadyM = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        hz_if.iRs1E = v.rs1e;  hz_if.iRs2E = v.rs2e;
        hz_if.iRdM  = v.rdm;   hz_if.iRegWriteM = v.wm;
        hz_if.iRdW  = v.rdw;   hz_if.iRegWriteW = v.ww;
        hz_if.iResultSrcE = v.rsrc; hz_if.iRdE = v.rde;
        hz_if.iRs1D = v.rs1d;  hz_if.iRs2D = v.rs2d;
        hz_if.iPCSrcE = v.pcsrc;
        hz_if.iMemReqM = v.mreq; hz_if.iMemReadyM = v.mrdy;
    endtask

    task automatic set_lu();
        hz_if.iResultSrcE = 2'b01; hz_if.iRdE = 5'd7; hz_if.iRs2D = 5'd7;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check("reset_stall_cnt", 32'(hz_if.oStallCycles), 32'd0);
        check("reset_flush_cnt", 32'(hz_if.oFlushCount), 32'd0);
        check("reset_timeout",   32'(hz_if.oMemTimeout), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        //          rs1e   rs2e   rdm   wm    rdw   ww   rsrc   rde    rs1d   rs2d  pc    mreq  mrdy  expected
        vecs[0]  = '{5'd5, 5'd0, 5'd5, 1'b1, 5'd5, 1'b1, 2'b00, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 11'b10_00_0000_000};
        vecs[1]  = '{5'd5, 5'd0, 5'd5, 1'b0, 5'd5, 1'b1, 2'b00, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 11'b01_00_0000_000};
        vecs[2]  = '{5'd5, 5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 2'b00, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 11'b01_00_0000_000};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 11'b00_00_0000_000};
        vecs[4]  = '{5'd3, 5'd9, 5'd3, 1'b1, 5'd9, 1'b1, 2'b00, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 11'b10_01_0000_000};
        vecs[5]  = '{5'd0, 5'd6, 5'd6, 1'b1, 5'd6, 1'b1, 2'b00, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 11'b00_10_0000_000};
        vecs[6]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd7,  5'd0,  5'd7, 1'b0, 1'b0, 1'b0, 11'b00_00_1100_010};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd12, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 11'b00_00_1100_010};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 11'b00_00_0000_000};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd7,  5'd7,  5'd0, 1'b0, 1'b0, 1'b0, 11'b00_00_0000_000};
        vecs[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b10, 5'd7,  5'd7,  5'd0, 1'b0, 1'b0, 1'b0, 11'b00_00_0000_000};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd7,  5'd0,  5'd7, 1'b1, 1'b0, 1'b0, 11'b00_00_0000_110};
        vecs[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0,  5'd0,  5'd0, 1'b1, 1'b0, 1'b0, 11'b00_00_0000_110};
        vecs[13] = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b1, 11'b00_00_0000_000};

        // Reset state, with forwarding and memory-stall conditions present
        idle();
        hz_if.iRs1E = 5'd5; hz_if.iRdM = 5'd5; hz_if.iRegWriteM = 1'b1;
        hz_if.iMemReqM = 1'b1;
        @(negedge clk); @(negedge clk);
        check("reset_ctl",       32'(ctl), 32'(11'b00_00_0000_110));
        check("reset_stall_cnt", 32'(hz_if.oStallCycles), 32'd0);
        check("reset_flush_cnt", 32'(hz_if.oFlushCount), 32'd0);
        check("reset_timeout",   32'(hz_if.oMemTimeout), 32'd0);
        idle();
        rst = 1'b0;
        @(negedge clk);

        // Vector table
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #2;
            check($sformatf("vec%0d", i), 32'(ctl), 32'(vecs[i].exp));
            @(negedge clk);
        end
        idle();
        pulse_reset();

        // Load-use: exactly one stall cycle, then the load has moved to M
        set_lu();
        #2 check("lu_stall", 32'(ctl), 32'(11'b00_00_1100_010));
        @(negedge clk);
        idle();
        hz_if.iRdM = 5'd7; hz_if.iRegWriteM = 1'b1;
        #2 check("lu_release", 32'(ctl), 32'(11'b00_00_0000_000));
        check("lu_stall_cnt", 32'(hz_if.oStallCycles), 32'd1);
        @(negedge clk);

        // Branch beats load-use
        idle();
        set_lu();
        hz_if.iPCSrcE = 1'b1;
        #2 check("br_over_lu", 32'(ctl), 32'(11'b00_00_0000_110));
        @(negedge clk);
        idle();
        #2 check("br_flush_cnt", 32'(hz_if.oFlushCount), 32'd1);
        check("br_stall_cnt", 32'(hz_if.oStallCycles), 32'd1);
        @(negedge clk);

        // Memory wait of 3 cycles; branch and load-use ignored while frozen
        for (int k = 0; k < 3; k++) begin
            set_lu();
            hz_if.iPCSrcE = 1'b1; hz_if.iMemReqM = 1'b1; hz_if.iMemReadyM = 1'b0;
            #2 check($sformatf("mw_stall%0d", k), 32'(ctl), 32'(11'b00_00_1111_001));
            @(negedge clk);
        end
        idle();
        hz_if.iMemReqM = 1'b1; hz_if.iMemReadyM = 1'b1;
        #2 check("mw_release", 32'(ctl), 32'(11'b00_00_0000_000));
        @(negedge clk);
        idle();
        #2 check("mw_back_run", 32'(ctl), 32'(11'b00_00_0000_000));
        check("mw_stall_cnt", 32'(hz_if.oStallCycles), 32'd4);
        check("mw_flush_cnt", 32'(hz_if.oFlushCount), 32'd1);
        @(negedge clk);

        // Timeout: 6 not-ready cycles, flag visible after 4 MEM_WAIT cycles
        for (int k = 0; k < 6; k++) begin
            hz_if.iMemReqM = 1'b1; hz_if.iMemReadyM = 1'b0;
            #2 check($sformatf("to_cycle%0d", k), 32'(hz_if.oMemTimeout), (k >= 5) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        hz_if.iMemReadyM = 1'b1;
        #2 check("to_at_release", 32'(hz_if.oMemTimeout), 32'd1);
        @(negedge clk);
        idle();
        #2 check("to_sticky", 32'(hz_if.oMemTimeout), 32'd1);
        check("to_stall_cnt", 32'(hz_if.oStallCycles), 32'd10);
        pulse_reset();

        // Reset asserted while in MEM_WAIT
        hz_if.iMemReqM = 1'b1; hz_if.iMemReadyM = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 check("rmw_pre_cnt", 32'(hz_if.oStallCycles), 32'd2);
        rst = 1'b1;
        #1 check("rmw_ctl", 32'(ctl), 32'(11'b00_00_0000_110));
        check("rmw_stall_cnt", 32'(hz_if.oStallCycles), 32'd0);
        rst = 1'b0;
        hz_if.iMemReqM = 1'b0;
        #1 check("rmw_run", 32'(ctl), 32'(11'b00_00_0000_000));
        @(negedge clk);

        // Counter saturation at 2**CNT_W-1
        idle();
        for (int k = 0; k < 20; k++) begin
            hz_if.iMemReqM = 1'b1; hz_if.iMemReadyM = 1'b0;
            @(negedge clk);
        end
        hz_if.iMemReadyM = 1'b1;
        @(negedge clk);
        idle();
        #2 check("sat_stall_cnt", 32'(hz_if.oStallCycles), 32'd15);
        check("sat_timeout", 32'(hz_if.oMemTimeout), 32'd1);
        for (int k = 0; k < 18; k++) begin
            hz_if.iPCSrcE = 1'b1;
            @(negedge clk);
        end
        idle();
        #2 check("sat_flush_cnt", 32'(hz_if.oFlushCount), 32'd15);
        check("sat_stall_hold", 32'(hz_if.oStallCycles), 32'd15);
        pulse_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
